bs_host_if: RTL and testbench

//  Host-side register interface sitting directly upstream of the Black-Scholes processor.

---
 rtl/bs_host_if_if.sv | 26 ++
 rtl/bs_host_if.sv | 192 +++++++++++++++++++
 tb/tb_bs_host_if.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bs_host_if_if.sv
// rtl/bs_host_if_if.sv - register bus and processor handshake bundle for bs_host_if
interface bs_host_if_if;
    logic        cs;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  proc_cmd;
    logic [31:0] proc_constK;
    logic [31:0] proc_const1;
    logic [31:0] proc_const2;
    logic [31:0] proc_const3;
    logic [3:0]  proc_status;
    logic [31:0] proc_dout;

    modport master (
        output cs, we, re, addr, wdata, proc_status, proc_dout,
        input  rdata, proc_cmd, proc_constK, proc_const1, proc_const2, proc_const3
    );

    modport slave (
        input  cs, we, re, addr, wdata, proc_status, proc_dout,
        output rdata, proc_cmd, proc_constK, proc_const1, proc_const2, proc_const3
    );
endinterface

// File: rtl/bs_host_if.sv
// rtl/bs_host_if.sv - host register block sequencing RUN/WAIT/ACK on the Black-Scholes processor
module bs_host_if #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CNT_W          = 21
) (
    input logic         clk,
    input logic         nreset,
    bs_host_if_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_RUN = 4'd1;
    localparam logic [3:0] CMD_ACK = 4'd2;

    localparam logic [3:0] PST_IDLE     = 4'd0;
    localparam logic [3:0] PST_RUNNING  = 4'd1;
    localparam logic [3:0] PST_COMPLETE = 4'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      k_q, k_d;
    logic [31:0]      c1_q, c1_d;
    logic [31:0]      c2_q, c2_d;
    logic [31:0]      c3_q, c3_d;
    logic [31:0]      result_q, result_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [3:0]       cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] status_word;
    logic [31:0] reg_rd;
    logic        at_limit;
    logic        abort;

    assign status_word = {24'd0, bus.proc_status, 1'b0, timeout_q, done_q, busy_q};

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        c3_d      = c3_q;
        result_d  = result_q;
        rdata_d   = rdata_q;
        cmd_d     = cmd_q;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        abort     = 1'b0;
        at_limit  = (cnt_q == CNT_LAST);

        case (bus.addr)
            3'd0:    reg_rd = k_q;
            3'd1:    reg_rd = c1_q;
            3'd2:    reg_rd = c2_q;
            3'd3:    reg_rd = c3_q;
            3'd5:    reg_rd = status_word;
            3'd6:    reg_rd = result_q;
            default: reg_rd = 32'd0;
        endcase

        // A simultaneous write takes the cycle; rdata keeps its last value.
        if (bus.cs && bus.re && !bus.we) begin
            rdata_d = reg_rd;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cs && bus.we) begin
                    case (bus.addr)
                        3'd0: k_d  = bus.wdata;
                        3'd1: c1_d = bus.wdata;
                        3'd2: c2_d = bus.wdata;
                        3'd3: c3_d = bus.wdata;
                        3'd4: begin
                            if (bus.wdata[0]) begin
                                state_d   = S_RUN;
                                cmd_d     = CMD_RUN;
                                busy_d    = 1'b1;
                                done_d    = 1'b0;
                                timeout_d = 1'b0;
                                cnt_d     = '0;
                            end else if (bus.wdata[1]) begin
                                done_d    = 1'b0;
                                timeout_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (bus.proc_status == PST_RUNNING) begin
                    state_d = S_WAIT;
                    cmd_d   = CMD_NOP;
                    cnt_d   = '0;
                end else if (at_limit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT: begin
                if (bus.proc_status == PST_COMPLETE) begin
                    state_d  = S_ACK;
                    cmd_d    = CMD_ACK;
                    result_d = bus.proc_dout;
                    cnt_d    = '0;
                end else if (at_limit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ACK: begin
                if (bus.proc_status == PST_IDLE) begin
                    state_d = S_IDLE;
                    cmd_d   = CMD_NOP;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (at_limit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cmd_d   = CMD_NOP;
                busy_d  = 1'b0;
            end
        endcase

        // Phase exhausted its cycle budget; RESULT is deliberately left alone.
        if (abort) begin
            state_d   = S_IDLE;
            cmd_d     = CMD_NOP;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            c3_q      <= '0;
            result_q  <= '0;
            rdata_q   <= '0;
            cmd_q     <= CMD_NOP;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            c3_q      <= c3_d;
            result_q  <= result_d;
            rdata_q   <= rdata_d;
            cmd_q     <= cmd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.proc_cmd    = cmd_q;
    assign bus.proc_constK = k_q;
    assign bus.proc_const1 = c1_q;
    assign bus.proc_const2 = c2_q;
    assign bus.proc_const3 = c3_q;
endmodule

// File: tb/tb_bs_host_if.sv
// tb/tb_bs_host_if.sv - directed bench for bs_host_if with a cycle-level reference model
module tb_bs_host_if;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic nreset = 1'b1;
    bs_host_if_if bus ();

    bs_host_if #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 run, 2 wait, 3 ack; each phase has an absolute deadline edge.
    int          cyc;
    int          m_phase;
    int          m_deadline;
    logic [31:0] m_k, m_c1, m_c2, m_c3, m_res, m_rdata;
    bit          m_busy, m_done, m_to;
    bit          exit_ok;

    function automatic logic [31:0] reg_view(input logic [2:0] a);
        case (a)
            3'd0: return m_k;
            3'd1: return m_c1;
            3'd2: return m_c2;
            3'd3: return m_c3;
            3'd5: return {24'd0, bus.proc_status, 1'b0, m_to, m_done, m_busy};
            3'd6: return m_res;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cyc = 0; m_phase = 0; m_deadline = 0;
            m_k = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0; m_res = 0; m_rdata = 0;
            m_busy = 0; m_done = 0; m_to = 0;
        end else begin
            cyc++;
            if (bus.cs && bus.re && !bus.we) m_rdata = reg_view(bus.addr);
            if (m_busy) begin
                exit_ok = (m_phase == 1 && bus.proc_status == 4'd1) ||
                          (m_phase == 2 && bus.proc_status == 4'd2) ||
                          (m_phase == 3 && bus.proc_status == 4'd0);
                if (exit_ok) begin
                    if (m_phase == 2) m_res = bus.proc_dout;
                    if (m_phase == 3) begin
                        m_phase = 0; m_busy = 0; m_done = 1;
                    end else begin
                        m_phase++; m_deadline = cyc + TO;
                    end
                end else if (cyc == m_deadline) begin
                    m_phase = 0; m_busy = 0; m_to = 1; m_done = 0;
                end
            end else if (bus.cs && bus.we) begin
                case (bus.addr)
                    3'd0: m_k = bus.wdata;
                    3'd1: m_c1 = bus.wdata;
                    3'd2: m_c2 = bus.wdata;
                    3'd3: m_c3 = bus.wdata;
                    3'd4: begin
                        if (bus.wdata[0]) begin
                            m_busy = 1; m_done = 0; m_to = 0; m_phase = 1; m_deadline = cyc + TO;
                        end else if (bus.wdata[1]) begin
                            m_done = 0; m_to = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata", bus.rdata, m_rdata);
            chk("proc_cmd", {28'd0, bus.proc_cmd}, (m_phase == 1) ? 32'd1 : (m_phase == 3) ? 32'd2 : 32'd0);
            chk("constK", bus.proc_constK, m_k);
            chk("const1", bus.proc_const1, m_c1);
            chk("const2", bus.proc_const2, m_c2);
            chk("const3", bus.proc_const3, m_c3);
        end
    end

    // Processor stand-in: answers RUN in one cycle, completes proc_delay cycles after WAIT begins.
    int p_state = 0;
    int p_cnt = 0;
    int proc_delay = 0;
    bit proc_run_ack = 1;
    bit proc_kick = 0;

    always @(negedge clk) begin
        if (!nreset || proc_kick) begin
            p_state = 0;
            bus.proc_status = 4'd0;
        end else begin
            case (p_state)
                0: if (bus.proc_cmd == 4'd1 && proc_run_ack) begin
                    bus.proc_status = 4'd1; p_state = 1;
                end
                1: if (bus.proc_cmd == 4'd0) begin
                    p_cnt = 0;
                    if (proc_delay == 0) begin bus.proc_status = 4'd2; p_state = 3; end
                    else p_state = 2;
                end
                2: begin
                    p_cnt++;
                    if (p_cnt == proc_delay) begin bus.proc_status = 4'd2; p_state = 3; end
                end
                3: if (bus.proc_cmd == 4'd2) begin
                    bus.proc_status = 4'd0; p_state = 0;
                end
                default: p_state = 0;
            endcase
        end
    end

    bit       rec_en = 0;
    logic [3:0] last_cmd = 4'd0;
    logic [3:0] cmd_seq[$];

    always @(negedge clk) begin
        if (rec_en && bus.proc_cmd != last_cmd) begin
            cmd_seq.push_back(bus.proc_cmd);
            last_cmd = bus.proc_cmd;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1; bus.we = 1; bus.re = 0; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.cs = 0; bus.we = 0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.cs = 1; bus.re = 1; bus.we = 0; bus.addr = a;
        @(negedge clk);
        bus.cs = 0; bus.re = 0;
        v = bus.rdata;
    endtask

    task automatic poll(input int bitn, input bit want, input int maxc, output int n, output bit ok);
        @(negedge clk);
        bus.cs = 1; bus.re = 1; bus.we = 0; bus.addr = 3'd5;
        ok = 0; n = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.rdata[bitn] == want) begin ok = 1; n = i; break; end
        end
        bus.cs = 0; bus.re = 0;
    endtask

    task automatic kick();
        proc_kick = 1;
        repeat (2) @(negedge clk);
        proc_kick = 0;
    endtask

    logic [31:0] v;
    int          n;
    bit          ok;

    initial begin
        bus.cs = 0; bus.we = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0;
        bus.proc_status = 0; bus.proc_dout = 0;
        #1 nreset = 0;
        #1 chk_en = 1;

        // T1 reset and basic register access
        repeat (3) @(negedge clk);
        chk("t1_rdata_rst", bus.rdata, 32'h0);
        chk("t1_cmd_rst", {28'd0, bus.proc_cmd}, 32'h0);
        #2 nreset = 1;
        rd(3'd5, v); chk("t1_status", v, 32'h0);
        wr(3'd0, 32'h10); wr(3'd1, 32'h20); wr(3'd2, 32'hABCD1234); wr(3'd3, 32'h11);
        wr(3'd7, 32'hFFFFFFFF);
        rd(3'd7, v); chk("t1_reserved", v, 32'h0);
        rd(3'd2, v); chk("t1_c2", v, 32'hABCD1234);
        @(negedge clk);
        bus.cs = 1; bus.we = 1; bus.re = 1; bus.addr = 3'd3; bus.wdata = 32'h40;
        @(negedge clk);
        bus.cs = 0; bus.we = 0; bus.re = 0;
        chk("t1_we_re_hold", bus.rdata, 32'hABCD1234);
        rd(3'd3, v); chk("t1_c3", v, 32'h40);

        // T2 full run, with T3 freeze checks while busy
        proc_delay = 50; bus.proc_dout = 32'hABCD1234;
        rec_en = 1;
        wr(3'd4, 32'h1);
        repeat (3) @(negedge clk);
        wr(3'd0, 32'h99);
        wr(3'd4, 32'h1);
        chk("t3_constK_frozen", bus.proc_constK, 32'h10);
        poll(1, 1'b1, 300, n, ok); chk("t2_done_seen", {31'd0, ok}, 32'd1);
        repeat (2) @(negedge clk);
        rec_en = 0;
        chk("t2_cmd_seq_len", cmd_seq.size(), 32'd4);
        if (cmd_seq.size() == 4) begin
            chk("t2_cmd_seq", {16'd0, cmd_seq[0], cmd_seq[1], cmd_seq[2], cmd_seq[3]}, 32'h1020);
        end
        rd(3'd6, v); chk("t2_result", v, 32'hABCD1234);
        rd(3'd5, v); chk("t2_status", v, 32'h02);
        rd(3'd0, v); chk("t3_k_kept", v, 32'h10);

        // T4 timeout in WAIT, then CLEAR
        proc_delay = -1; bus.proc_dout = 32'h0BAD0BAD;
        wr(3'd4, 32'h1);
        poll(2, 1'b1, 300, n, ok); chk("t4_timeout_seen", {31'd0, ok}, 32'd1);
        chk("t4_wait_cycles", n, TO);
        rd(3'd5, v); chk("t4_status", v, 32'h14);
        rd(3'd6, v); chk("t4_result_kept", v, 32'hABCD1234);
        wr(3'd4, 32'h2);
        rd(3'd5, v); chk("t4_clear", v, 32'h10);
        kick();

        // T5 completion on the last allowed cycle, then one cycle too late
        proc_delay = TO - 1; bus.proc_dout = 32'h5A5A0001;
        wr(3'd4, 32'h1);
        poll(0, 1'b0, 400, n, ok); chk("t5_idle_seen", {31'd0, ok}, 32'd1);
        rd(3'd5, v); chk("t5_status", v, 32'h02);
        rd(3'd6, v); chk("t5_result", v, 32'h5A5A0001);
        proc_delay = TO; bus.proc_dout = 32'h11112222;
        wr(3'd4, 32'h1);
        poll(0, 1'b0, 400, n, ok); chk("t5b_idle_seen", {31'd0, ok}, 32'd1);
        rd(3'd5, v); chk("t5b_status", v, 32'h24);
        rd(3'd6, v); chk("t5b_result_kept", v, 32'h5A5A0001);
        kick();

        // T6 reset mid-WAIT and mid-RUN, then a clean run
        proc_delay = 20;
        wr(3'd4, 32'h1);
        repeat (8) @(negedge clk);
        #2 nreset = 0;
        #1 chk("t6_cmd_wait_rst", {28'd0, bus.proc_cmd}, 32'h0);
        repeat (2) @(negedge clk);
        #2 nreset = 1;
        rd(3'd0, v); chk("t6_k_rst", v, 32'h0);
        rd(3'd6, v); chk("t6_result_rst", v, 32'h0);
        rd(3'd5, v); chk("t6_status_rst", v, 32'h0);
        proc_run_ack = 0;
        wr(3'd4, 32'h1);
        #2 chk("t6_cmd_run", {28'd0, bus.proc_cmd}, 32'h1);
        nreset = 0;
        #1 chk("t6_cmd_async", {28'd0, bus.proc_cmd}, 32'h0);
        repeat (2) @(negedge clk);
        #2 nreset = 1;
        proc_run_ack = 1; proc_delay = 3; bus.proc_dout = 32'hCAFEF00D;
        wr(3'd0, 32'h77);
        wr(3'd4, 32'h1);
        poll(1, 1'b1, 100, n, ok); chk("t6_done_seen", {31'd0, ok}, 32'd1);
        rd(3'd6, v); chk("t6_result", v, 32'hCAFEF00D);
        rd(3'd0, v); chk("t6_k", v, 32'h77);
        rd(3'd5, v); chk("t6_status", v, 32'h02);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
